commit_trace_merger: RTL and testbench

//  Merges the two per-cycle commit debug ports (slot0 = older, slot1 = younger) into one
//  in-order stream of register-write records, one record per handshake.

---
 rtl/trace_pkg.sv | 24 ++
 rtl/trace_fifo_2w1r.sv | 59 +++++
 rtl/commit_trace_merger.sv | 141 ++++++++++++++
 tb/tb_commit_trace_merger.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and helpers for the commit trace merger.
package trace_pkg;

    // One register-write record, as carried through the merge FIFO.
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } trace_rec_t;

    localparam int TRACE_REC_W = 73;

    // Zero every data byte whose write enable is clear.
    function automatic logic [31:0] mask_wdata(input logic [3:0] wen, input logic [31:0] wdata);
        logic [31:0] masked;
        masked = 32'd0;
        for (int i = 0; i < 4; i++) begin
            masked[i*8 +: 8] = wdata[i*8 +: 8] & {8{wen[i]}};
        end
        return masked;
    endfunction

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Register FIFO with up to two in-order writes and one read per cycle.
// Record A is always written before record B; B is only written together with A.
// The head entry is read straight from the register array.
module trace_fifo_2w1r
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             sys_clk,
    input  logic             resetn,
    input  logic             i_push_a,
    input  trace_rec_t       i_rec_a,
    input  logic             i_push_b,
    input  trace_rec_t       i_rec_b,
    input  logic             i_pop,
    output trace_rec_t       o_head,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_rec_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [PTR_W-1:0] w_wr_ptr_b;
    logic             w_pop;

    assign w_wr_ptr_b = r_wr_ptr + PTR_W'(1);
    assign w_pop      = i_pop && (r_level != '0);
    assign o_head     = r_mem[r_rd_ptr];
    assign o_level    = r_level;

    // Storage writes: A at the write pointer, B in the slot right after it.
    always_ff @(posedge sys_clk) begin
        if (i_push_a) begin
            r_mem[r_wr_ptr] <= i_rec_a;
        end
        if (i_push_a && i_push_b) begin
            r_mem[w_wr_ptr_b] <= i_rec_b;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_a) + PTR_W'(i_push_a && i_push_b);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_level  <= r_level + LVL_W'(i_push_a) + LVL_W'(i_push_a && i_push_b)
                        - LVL_W'(w_pop);
        end
    end

endmodule

// File: rtl/commit_trace_merger.sv
// Merges the dual-issue commit debug ports into one in-order register-write stream.
// Filters non-writes, buffers bursts, counts dropped records and detects END_PC.
// Optional build macro: TRACE_BYTE_MASK_EN (stored wdata masked per byte by wen).
module commit_trace_merger
    import trace_pkg::*;
#(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = 32'hbfc00100,
    parameter int          CNT_W  = 16
) (
    input  logic                     sys_clk,
    input  logic                     resetn,
    input  logic                     trace_en,
    input  logic [31:0]              wb_pc0,
    input  logic [3:0]               wb_wen0,
    input  logic [4:0]               wb_wnum0,
    input  logic [31:0]              wb_wdata0,
    input  logic [31:0]              wb_pc1,
    input  logic [3:0]               wb_wen1,
    input  logic [4:0]               wb_wnum1,
    input  logic [31:0]              wb_wdata1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [3:0]               out_wen,
    output logic [4:0]               out_wnum,
    output logic [31:0]              out_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     trace_end
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_trace_end;

    logic             w_active;
    logic             w_cap0;
    logic             w_cap1;
    logic             w_end0;
    logic             w_end1;
    logic [1:0]       w_want;
    logic [1:0]       w_accept;
    logic [1:0]       w_drop;
    logic [LVL_W-1:0] w_free;
    logic [LVL_W-1:0] w_level;
    logic [CNT_W:0]   w_drop_sum;
    trace_rec_t       w_rec0;
    trace_rec_t       w_rec1;
    trace_rec_t       w_rec_a;
    trace_rec_t       w_head;
    logic             w_push_a;
    logic             w_push_b;

    // Build the candidate records, masking data bytes only when the feature is built in.
    always_comb begin
        w_rec0.pc   = wb_pc0;
        w_rec0.wen  = wb_wen0;
        w_rec0.wnum = wb_wnum0;
        w_rec1.pc   = wb_pc1;
        w_rec1.wen  = wb_wen1;
        w_rec1.wnum = wb_wnum1;
`ifdef TRACE_BYTE_MASK_EN
        w_rec0.wdata = mask_wdata(wb_wen0, wb_wdata0);
        w_rec1.wdata = mask_wdata(wb_wen1, wb_wdata1);
`else
        w_rec0.wdata = wb_wdata0;
        w_rec1.wdata = wb_wdata1;
`endif
    end

    // Filter, end detection and space arbitration; slot0 always wins the last free entry.
    always_comb begin
        w_active = trace_en && !r_trace_end;
        w_end0   = w_active && (wb_pc0 == END_PC);
        w_end1   = w_active && (wb_pc1 == END_PC);
        w_cap0   = w_active && (|wb_wen0) && (wb_wnum0 != 5'd0);
        // A younger slot behind the END commit is discarded outright, not dropped.
        w_cap1   = w_active && (|wb_wen1) && (wb_wnum1 != 5'd0) && !w_end0;
        w_want   = 2'(w_cap0) + 2'(w_cap1);
        // Free space ignores any pop happening in this same cycle.
        w_free   = LVL_W'(DEPTH) - w_level;
        if (w_free >= LVL_W'(w_want)) begin
            w_accept = w_want;
        end else begin
            w_accept = w_free[1:0];
        end
        w_drop   = w_want - w_accept;
        w_push_a = (w_accept != 2'd0);
        w_push_b = (w_accept == 2'd2);
        w_rec_a  = w_cap0 ? w_rec0 : w_rec1;
        w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W + 1)'(w_drop);
    end

    // Sticky status flags and the saturating drop counter.
    always_ff @(posedge sys_clk) begin
        if (!resetn) begin
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
            r_trace_end <= 1'b0;
        end else begin
            if (w_drop != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
            end
            if (w_end0 || w_end1) begin
                r_trace_end <= 1'b1;
            end
        end
    end

    trace_fifo_2w1r #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .resetn   (resetn),
        .i_push_a (w_push_a),
        .i_rec_a  (w_rec_a),
        .i_push_b (w_push_b),
        .i_rec_b  (w_rec1),
        .i_pop    (out_valid && out_ready),
        .o_head   (w_head),
        .o_level  (w_level)
    );

    // Data fields read as zero while the FIFO is empty, so they are zero out of reset.
    assign out_valid = (w_level != '0);
    assign out_pc    = out_valid ? w_head.pc    : 32'd0;
    assign out_wen   = out_valid ? w_head.wen   : 4'd0;
    assign out_wnum  = out_valid ? w_head.wnum  : 5'd0;
    assign out_wdata = out_valid ? w_head.wdata : 32'd0;
    assign level     = w_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign trace_end = r_trace_end;

endmodule

// File: tb/tb_commit_trace_merger.sv
// Scoreboard bench for commit_trace_merger: stimulus queues expected records,
// a negedge monitor pops and compares every accepted output record.
module tb_commit_trace_merger;
    import trace_pkg::*;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] END_PC = 32'hbfc00100;
    localparam int          CNT_W  = 16;

    logic                   sys_clk = 1'b0;
    logic                   resetn;
    logic                   trace_en;
    logic [31:0]            wb_pc0, wb_pc1, wb_wdata0, wb_wdata1;
    logic [3:0]             wb_wen0, wb_wen1;
    logic [4:0]             wb_wnum0, wb_wnum1;
    logic                   out_valid, out_ready;
    logic [31:0]            out_pc, out_wdata;
    logic [3:0]             out_wen;
    logic [4:0]             out_wnum;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow, trace_end;
    logic [CNT_W-1:0]       drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    trace_rec_t exp_q[$];

    always #5 sys_clk = ~sys_clk;

    commit_trace_merger #(.DEPTH(DEPTH), .END_PC(END_PC), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .resetn(resetn), .trace_en(trace_en),
        .wb_pc0(wb_pc0), .wb_wen0(wb_wen0), .wb_wnum0(wb_wnum0), .wb_wdata0(wb_wdata0),
        .wb_pc1(wb_pc1), .wb_wen1(wb_wen1), .wb_wnum1(wb_wnum1), .wb_wdata1(wb_wdata1),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_wen(out_wen),
        .out_wnum(out_wnum), .out_wdata(out_wdata), .level(level), .overflow(overflow),
        .drop_cnt(drop_cnt), .trace_end(trace_end)
    );

    function automatic trace_rec_t mk(input logic [31:0] pc, input logic [3:0] wen,
                                      input logic [4:0] wnum, input logic [31:0] wdata);
        trace_rec_t r;
        r.pc = pc; r.wen = wen; r.wnum = wnum; r.wdata = wdata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_slots();
        wb_pc0 = 32'd0; wb_wen0 = 4'd0; wb_wnum0 = 5'd0; wb_wdata0 = 32'd0;
        wb_pc1 = 32'd0; wb_wen1 = 4'd0; wb_wnum1 = 5'd0; wb_wdata1 = 32'd0;
    endtask

    task automatic set_slots(input logic [31:0] pc0, input logic [3:0] wen0,
                             input logic [4:0] n0, input logic [31:0] d0,
                             input logic [31:0] pc1, input logic [3:0] wen1,
                             input logic [4:0] n1, input logic [31:0] d1);
        wb_pc0 = pc0; wb_wen0 = wen0; wb_wnum0 = n0; wb_wdata0 = d0;
        wb_pc1 = pc1; wb_wen1 = wen1; wb_wnum1 = n1; wb_wdata1 = d1;
    endtask

    task automatic drain(input string name);
        int cyc;
        out_ready = 1'b1;
        cyc = 0;
        while ((level != '0) && (cyc < 100)) begin
            tick();
            cyc++;
        end
        @(negedge sys_clk);
        chk({name, "_drained_level"}, 32'(level), 32'd0);
        chk({name, "_scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every accepted output record must match the head of the expected queue.
    always @(negedge sys_clk) begin
        if (resetn && out_valid && out_ready) begin
            trace_rec_t e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_record: got pc=0x%08h r%0d data=0x%08h, required none",
                         out_pc, out_wnum, out_wdata);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_wen !== e.wen || out_wnum !== e.wnum ||
                    out_wdata !== e.wdata) begin
                    n_fail++;
                    $display("[TB] FAIL record: got pc=0x%08h wen=%h r%0d data=0x%08h, required pc=0x%08h wen=%h r%0d data=0x%08h",
                             out_pc, out_wen, out_wnum, out_wdata, e.pc, e.wen, e.wnum, e.wdata);
                end else begin
                    $display("[TB] ok   record: pc=0x%08h r%0d data=0x%08h", out_pc, out_wnum, out_wdata);
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_masked;
        resetn = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
        idle_slots();
        tick(); tick();
        resetn = 1'b1;
        @(negedge sys_clk);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("reset_trace_end", 32'(trace_end), 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);

        // 1: both slots write, consumer ready.
        tick();
        trace_en = 1'b1; out_ready = 1'b1;
        set_slots(32'hbfc00000, 4'hf, 5'd2, 32'h11, 32'hbfc00004, 4'hf, 5'd3, 32'h22);
        exp_q.push_back(mk(32'hbfc00000, 4'hf, 5'd2, 32'h11));
        exp_q.push_back(mk(32'hbfc00004, 4'hf, 5'd3, 32'h22));
        tick();
        idle_slots();
        @(negedge sys_clk);
        chk("t1_level_after_push", 32'(level), 32'd2);
        drain("t1");

        // 2: wnum=0 on slot0, wen=0 on slot1 -> nothing captured.
        tick();
        set_slots(32'hbfc00008, 4'hf, 5'd0, 32'h33, 32'hbfc0000c, 4'h0, 5'd6, 32'h44);
        tick();
        idle_slots();
        @(negedge sys_clk);
        chk("t2_level", 32'(level), 32'd0);
        chk("t2_valid", 32'(out_valid), 32'd0);

        // 3: 9 dual-write cycles with consumer stalled; last cycle's pair is dropped.
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            set_slots(32'h1000 + 32'(8*k), 4'hf, 5'd1, 32'ha000_0000 + 32'(2*k),
                      32'h1004 + 32'(8*k), 4'hf, 5'd2, 32'ha000_0001 + 32'(2*k));
            if (k < 8) begin
                exp_q.push_back(mk(32'h1000 + 32'(8*k), 4'hf, 5'd1, 32'ha000_0000 + 32'(2*k)));
                exp_q.push_back(mk(32'h1004 + 32'(8*k), 4'hf, 5'd2, 32'ha000_0001 + 32'(2*k)));
            end
            tick();
        end
        idle_slots();
        @(negedge sys_clk);
        chk("t3_level_full", 32'(level), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        tick();
        drain("t3");

        // 4: prefill 4 records, then slot0 at END_PC; slot1 discarded, nothing after.
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_slots(32'h2000 + 32'(8*k), 4'hf, 5'd7, 32'hc0 + 32'(k),
                      32'h2004 + 32'(8*k), 4'hf, 5'd8, 32'hd0 + 32'(k));
            exp_q.push_back(mk(32'h2000 + 32'(8*k), 4'hf, 5'd7, 32'hc0 + 32'(k)));
            exp_q.push_back(mk(32'h2004 + 32'(8*k), 4'hf, 5'd8, 32'hd0 + 32'(k)));
            tick();
        end
        set_slots(END_PC, 4'hf, 5'd4, 32'h44444444, END_PC + 32'd4, 4'hf, 5'd5, 32'h55555555);
        exp_q.push_back(mk(END_PC, 4'hf, 5'd4, 32'h44444444));
        tick();
        set_slots(32'h3000, 4'hf, 5'd9, 32'h99, 32'h3004, 4'hf, 5'd10, 32'haa);
        tick();
        idle_slots();
        @(negedge sys_clk);
        chk("t4_trace_end", 32'(trace_end), 32'd1);
        chk("t4_level", 32'(level), 32'd5);
        chk("t4_drop_cnt_unchanged", 32'(drop_cnt), 32'd2);

        // 6: one-edge reset with 5 records buffered.
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        exp_q.delete();
        @(negedge sys_clk);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        chk("t6_trace_end", 32'(trace_end), 32'd0);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);

        // 5: partial byte enables; masking depends on the build macro.
`ifdef TRACE_BYTE_MASK_EN
        exp_masked = 32'h0000beef;
`else
        exp_masked = 32'hdeadbeef;
`endif
        tick();
        set_slots(32'h4000, 4'b0011, 5'd12, 32'hdeadbeef, 32'h4004, 4'h0, 5'd0, 32'h0);
        exp_q.push_back(mk(32'h4000, 4'b0011, 5'd12, exp_masked));
        tick();
        idle_slots();
        @(negedge sys_clk);
        chk("t5_level", 32'(level), 32'd1);
        drain("t5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
